z16_decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the Z16 core. It replaces the purely combinational decoder between fetch and execute.
- Decodes the full Z16 opcode map and sign-extends immediates to a parametrised datapath width.
- Buffers one instruction in a skid entry so that o_ready is a registered signal.
- Inserts a one-cycle bubble on a load-use hazard and counts those bubbles.

---
 rtl/z16_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_z16_decode_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/z16_decode_stage.sv
// Z16 registered decode stage: one output bundle register plus one raw skid entry.
// Optional load-use interlock: define Z16_DECODE_LOAD_USE_INTERLOCK_EN.
module z16_decode_stage #(
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [15:0]            i_instr,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_flush,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [3:0]             o_opcode,
    output logic [3:0]             o_rd_addr,
    output logic [3:0]             o_rs1_addr,
    output logic [3:0]             o_rs2_addr,
    output logic [DATA_W-1:0]      o_imm,
    output logic                   o_rd_wen,
    output logic                   o_mem_wen,
    output logic                   o_mem_ren,
    output logic [3:0]             o_alu_ctrl,
    output logic                   o_illegal,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    logic              r_valid;
    logic              r_ready;
    logic              r_skid_valid;
    logic [15:0]       r_skid_instr;
    logic [3:0]        r_opcode;
    logic [3:0]        r_rd_addr;
    logic [3:0]        r_rs1_addr;
    logic [3:0]        r_rs2_addr;
    logic [DATA_W-1:0] r_imm;
    logic              r_rd_wen;
    logic              r_mem_wen;
    logic              r_mem_ren;
    logic [3:0]        r_alu_ctrl;
    logic              r_illegal;

    logic              w_acc;
    logic              w_xfer;
    logic              w_out_free;
    logic              w_cand_valid;
    logic              w_load_out;
    logic              w_skid_valid_n;
    logic              w_haz;
    logic [15:0]       w_cand;
    logic [3:0]        w_op;
    logic [3:0]        w_rs2;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_imm4;
    logic              w_rd_wen;
    logic              w_mem_wen;
    logic              w_mem_ren;
    logic [3:0]        w_alu_ctrl;
    logic              w_illegal;

    // The skid entry is always older than the input, so it goes first.
    assign w_acc          = i_valid && r_ready;
    assign w_xfer         = r_valid && i_ready;
    assign w_out_free     = !r_valid || i_ready;
    assign w_cand_valid   = r_skid_valid || w_acc;
    assign w_cand         = r_skid_valid ? r_skid_instr : i_instr;
    assign w_op           = w_cand[3:0];
    assign w_imm4         = {{(DATA_W-4){w_cand[15]}}, w_cand[15:12]};
    assign w_load_out     = w_out_free && w_cand_valid && !w_haz;
    assign w_skid_valid_n = w_cand_valid && !w_load_out;

    always_comb begin
        w_rs2      = 4'h0;
        w_imm      = '0;
        w_rd_wen   = 1'b0;
        w_mem_wen  = 1'b0;
        w_mem_ren  = 1'b0;
        w_alu_ctrl = 4'h0;
        w_illegal  = 1'b0;
        unique case (1'b1)
            (w_op <= 4'h8): begin
                w_rs2      = w_cand[15:12];
                w_rd_wen   = 1'b1;
                w_alu_ctrl = w_op;
            end
            (w_op == 4'hA): begin
                w_imm    = w_imm4;
                w_rd_wen = 1'b1;
            end
            (w_op == 4'hB): begin
                w_imm     = w_imm4;
                w_rd_wen  = 1'b1;
                w_mem_ren = 1'b1;
            end
            (w_op == 4'hC): begin
                w_imm     = w_imm4;
                w_mem_wen = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef Z16_DECODE_LOAD_USE_INTERLOCK_EN
    logic                   w_reads_rd;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_reads_rd = 1'b0;
        unique case (1'b1)
            (w_op <= 4'h8):
                w_reads_rd = (w_cand[11:8] == r_rd_addr) ||
                             (w_cand[15:12] == r_rd_addr);
            (w_op == 4'hA),
            (w_op == 4'hB):
                w_reads_rd = (w_cand[11:8] == r_rd_addr);
            (w_op == 4'hC):
                w_reads_rd = (w_cand[11:8] == r_rd_addr) ||
                             (w_cand[7:4] == r_rd_addr);
            default: w_reads_rd = 1'b0;
        endcase
    end

    // A load leaving while its consumer would enter: park the consumer one cycle.
    assign w_haz = w_xfer && r_mem_ren && w_cand_valid &&
                   w_reads_rd && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_haz && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign w_haz       = 1'b0;
    assign o_stall_cnt = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_ready      <= 1'b1;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 16'h0;
            r_opcode     <= 4'h0;
            r_rd_addr    <= 4'h0;
            r_rs1_addr   <= 4'h0;
            r_rs2_addr   <= 4'h0;
            r_imm        <= '0;
            r_rd_wen     <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_alu_ctrl   <= 4'h0;
            r_illegal    <= 1'b0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_ready      <= 1'b1;
            r_skid_valid <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_n;
            r_ready      <= !w_skid_valid_n;
            if (w_skid_valid_n) begin
                r_skid_instr <= w_cand;
            end
            if (w_load_out) begin
                r_valid    <= 1'b1;
                r_opcode   <= w_op;
                r_rd_addr  <= w_cand[7:4];
                r_rs1_addr <= w_cand[11:8];
                r_rs2_addr <= w_rs2;
                r_imm      <= w_imm;
                r_rd_wen   <= w_rd_wen;
                r_mem_wen  <= w_mem_wen;
                r_mem_ren  <= w_mem_ren;
                r_alu_ctrl <= w_alu_ctrl;
                r_illegal  <= w_illegal;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_opcode   = r_opcode;
    assign o_rd_addr  = r_rd_addr;
    assign o_rs1_addr = r_rs1_addr;
    assign o_rs2_addr = r_rs2_addr;
    assign o_imm      = r_imm;
    assign o_rd_wen   = r_rd_wen;
    assign o_mem_wen  = r_mem_wen;
    assign o_mem_ren  = r_mem_ren;
    assign o_alu_ctrl = r_alu_ctrl;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Directed bench for z16_decode_stage: decode table, backpressure,
// load-use, flush and reset sequences.
module tb_z16_decode_stage;

`ifdef Z16_DECODE_LOAD_USE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] i_instr;
    logic        i_valid;
    logic        i_flush;
    logic        i_ready;

    logic        o_ready, o_valid, o_rd_wen, o_mem_wen, o_mem_ren, o_illegal;
    logic [3:0]  o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
    logic [15:0] o_imm, o_stall_cnt;

    logic        d32_ready, d32_valid, d32_rd_wen, d32_mem_wen, d32_mem_ren, d32_illegal;
    logic [3:0]  d32_opcode, d32_rd_addr, d32_rs1_addr, d32_rs2_addr, d32_alu_ctrl;
    logic [31:0] d32_imm;
    logic [15:0] d32_stall_cnt;

    int checks = 0;
    int errors = 0;

    z16_decode_stage #(.DATA_W(16), .STALL_CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_opcode(o_opcode), .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_imm(o_imm), .o_rd_wen(o_rd_wen),
        .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_alu_ctrl(o_alu_ctrl),
        .o_illegal(o_illegal), .o_stall_cnt(o_stall_cnt)
    );

    z16_decode_stage #(.DATA_W(32), .STALL_CNT_W(16)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_valid(i_valid),
        .o_ready(d32_ready), .i_flush(i_flush), .o_valid(d32_valid), .i_ready(i_ready),
        .o_opcode(d32_opcode), .o_rd_addr(d32_rd_addr), .o_rs1_addr(d32_rs1_addr),
        .o_rs2_addr(d32_rs2_addr), .o_imm(d32_imm), .o_rd_wen(d32_rd_wen),
        .o_mem_wen(d32_mem_wen), .o_mem_ren(d32_mem_ren), .o_alu_ctrl(d32_alu_ctrl),
        .o_illegal(d32_illegal), .o_stall_cnt(d32_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic        rdw;
        logic        mw;
        logic        mr;
        logic [3:0]  alu;
        logic        ill;
    } vec_t;

    vec_t vt[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        vt[0]  = '{16'hF21A, 4'h1, 4'h2, 4'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[1]  = '{16'h5340, 4'h4, 4'h3, 4'h5, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vt[2]  = '{16'h7658, 4'h5, 4'h6, 4'h7, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h8, 1'b0};
        vt[3]  = '{16'h3213, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0};
        vt[4]  = '{16'h013B, 4'h3, 4'h1, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
        vt[5]  = '{16'h812B, 4'h2, 4'h1, 4'h0, 16'hFFF8, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
        vt[6]  = '{16'h7A4C, 4'h4, 4'hA, 4'h0, 16'h0007, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
        vt[7]  = '{16'h000D, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
        vt[8]  = '{16'hFFF9, 4'hF, 4'hF, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
        vt[9]  = '{16'h123F, 4'h3, 4'h2, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
        vt[10] = '{16'h456E, 4'h6, 4'h5, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};

        // Reset held with valid input offered
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_instr = 16'hF21A;
        i_ready = 1'b1;
        i_flush = 1'b0;
        repeat (3) step();
        chk("rst_ctl", {o_valid, o_ready, o_stall_cnt}, {1'b0, 1'b1, 16'h0});
        chk("rst_out", {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm,
                        o_rd_wen, o_mem_wen, o_mem_ren, o_alu_ctrl, o_illegal}, 64'h0);
        chk("rst32", {d32_ready, d32_valid, d32_stall_cnt}, {1'b1, 1'b0, 16'h0});
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        step();
        i_valid = 1'b1;
        step();
        chk("first_issue", {o_valid, o_rd_addr, o_imm}, {1'b1, 4'h1, 16'hFFFF});
        i_valid = 1'b0;
        step();
        chk("first_drain", o_valid, 1'b0);

        // Decode table, one isolated instruction at a time
        for (int i = 0; i < 11; i++) begin
            i_instr = vt[i].instr;
            i_valid = 1'b1;
            step();
            chk($sformatf("valid_v%0d", i), o_valid, 1'b1);
            chk($sformatf("dec_v%0d", i),
                {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm,
                 o_rd_wen, o_mem_wen, o_mem_ren, o_alu_ctrl, o_illegal},
                {vt[i].instr[3:0], vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm,
                 vt[i].rdw, vt[i].mw, vt[i].mr, vt[i].alu, vt[i].ill});
            chk($sformatf("dec32_v%0d", i),
                {d32_valid, d32_opcode, d32_rd_addr, d32_rs1_addr, d32_rs2_addr, d32_imm,
                 d32_rd_wen, d32_mem_wen, d32_mem_ren, d32_alu_ctrl, d32_illegal},
                {1'b1, vt[i].instr[3:0], vt[i].rd, vt[i].rs1, vt[i].rs2,
                 {{16{vt[i].imm[15]}}, vt[i].imm},
                 vt[i].rdw, vt[i].mw, vt[i].mr, vt[i].alu, vt[i].ill});
            i_valid = 1'b0;
            step();
        end

        // Backpressure: two accepts fill output and skid
        i_ready = 1'b0;
        i_instr = 16'h213A;
        i_valid = 1'b1;
        step();
        chk("bp_first", {o_valid, o_ready, o_opcode, o_rd_addr}, {1'b1, 1'b1, 4'hA, 4'h3});
        i_instr = 16'h0030;
        step();
        chk("bp_skid", {o_valid, o_ready, o_opcode}, {1'b1, 1'b0, 4'hA});
        i_instr = 16'h7658;
        step();
        chk("bp_hold1", {o_valid, o_ready, o_opcode}, {1'b1, 1'b0, 4'hA});
        step();
        chk("bp_hold2", {o_valid, o_ready, o_opcode, o_imm}, {1'b1, 1'b0, 4'hA, 16'h0002});
        i_ready = 1'b1;
        step();
        chk("bp_second", {o_valid, o_ready, o_opcode, o_rd_addr, o_rs1_addr},
            {1'b1, 1'b1, 4'h0, 4'h3, 4'h0});
        step();
        chk("bp_third", {o_valid, o_opcode, o_rd_addr}, {1'b1, 4'h8, 4'h5});
        i_valid = 1'b0;
        step();
        chk("bp_empty", o_valid, 1'b0);

        // Load-use: LOAD r3 then ADD r4 = r3 + r5
        i_instr = 16'h013B;
        i_valid = 1'b1;
        step();
        chk("lu_load", {o_valid, o_opcode, o_mem_ren}, {1'b1, 4'hB, 1'b1});
        i_instr = 16'h5340;
        step();
        chk("lu_bubble", {o_valid, o_stall_cnt}, {!IL, IL ? 16'd1 : 16'd0});
        i_valid = 1'b0;
        if (IL) step();
        chk("lu_add", {o_valid, o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr},
            {1'b1, 4'h0, 4'h4, 4'h3, 4'h5});
        step();
        chk("lu_once", {o_valid, o_stall_cnt}, {1'b0, IL ? 16'd1 : 16'd0});

        // Flush with output and skid full and a new input offered
        i_ready = 1'b0;
        i_instr = 16'h213A;
        i_valid = 1'b1;
        step();
        i_instr = 16'h0030;
        step();
        chk("fl_full", {o_valid, o_ready}, {1'b1, 1'b0});
        i_instr = 16'h7658;
        i_flush = 1'b1;
        step();
        chk("fl_after", {o_valid, o_ready, o_stall_cnt}, {1'b0, 1'b1, IL ? 16'd1 : 16'd0});
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fl_quiet%0d", k), o_valid, 1'b0);
        end
        i_instr = 16'hF21A;
        i_valid = 1'b1;
        step();
        chk("fl_next", {o_valid, o_opcode, o_rd_addr}, {1'b1, 4'hA, 4'h1});
        i_valid = 1'b0;

        // Asynchronous reset while a bundle is stalled in the output
        i_ready = 1'b0;
        i_instr = 16'h3213;
        i_valid = 1'b1;
        step();
        step();
        chk("ar_pre", {o_valid, o_ready}, {1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ctl", {o_valid, o_ready, o_stall_cnt}, {1'b0, 1'b1, 16'h0});
        chk("ar_out", {o_opcode, o_rd_addr, o_rs1_addr, o_imm, o_rd_wen}, 64'h0);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        step();
        step();
        chk("ar_nodup", o_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
